covariance_accumulator: RTL and testbench
=========================================

Name: covariance_accumulator

Overview:
- Next stage after centering in the FastICA front end.
- Once centering is finished, it reads the centered two-channel samples from the sample RAM.
- Accumulates the three products x1*x1, x1*x2 and x2*x2, then divides each sum by N (an arithmetic right shift).
- Presents the 2x2 covariance terms C11, C12 and C22 to the whitening stage, with a busy/done handshake.

Parameters:
- DW, 16, signed sample width per channel.
- LOG2N, 7, log2 of the sample count; N = 2^LOG2N = 128.
- AW, 7, RAM address width; must equal LOG2N.

Ports:
- CLK_cov  in  1  block clock.
- GO_cov  in  1  asynchronous active-low reset.
- START  in  1  single-cycle start pulse, driven by centering completion.
- RD_En  out  1  sample RAM read enable.
- RD_Addr  out  AW  sample RAM read address.
- RD_X1  in  DW  centered channel-1 sample, signed.
- RD_X2  in  DW  centered channel-2 sample, signed.
- COV_Busy  out  1  high while a computation is running.
- COV_Done  out  1  high while results are valid.
- C11  out  2*DW  mean of x1*x1, signed.
- C12  out  2*DW  mean of x1*x2, signed.
- C22  out  2*DW  mean of x2*x2, signed.

Behaviour:
- Reset (GO_cov low, asynchronous): state IDLE. All of the following clear to 0: RD_En, RD_Addr, COV_Busy, COV_Done, C11, C12, C22, the three accumulators, the address counter and the valid pipe bit.
- RAM contract: synchronous read. RD_X1/RD_X2 carry the data for the address presented in cycle k during cycle k+1.
- Edge numbering: e0 is the edge that samples START=1 in IDLE or DONE.
- States:
  - IDLE: outputs at reset values. START=1 -> RUN; clear accumulators and address counter.
  - RUN: RD_En=1, COV_Busy=1, RD_Addr = counter. The counter increments every edge. When counter = N-1 -> DRAIN; counter wraps to 0.
  - DRAIN: RD_En=0, COV_Busy=1. Lasts one cycle so the last sample can be accumulated. -> SCALE.
  - SCALE: COV_Busy=1. Registers each result as acc >>> LOG2N, truncated to 2*DW bits. -> DONE.
  - DONE: COV_Busy=0, COV_Done=1, results held. START=1 -> RUN as a restart: COV_Done drops and the accumulators clear on that edge.
- Accumulation:
  - rd_v is RD_En delayed by one register stage.
  - On every edge with rd_v=1: acc11 += x1*x1, acc12 += x1*x2, acc22 += x2*x2.
  - Products are full signed 2*DW bits. Accumulators are 2*DW+LOG2N bits, signed and sign-extended, so there is no overflow for any input.
- Timing:
  - Addresses 0..N-1 are driven in the cycles following e0..e(N-1).
  - The last accumulate happens at e(N+1). Results register and COV_Done rises at e(N+2).
  - COV_Busy is high from e0 until e(N+2).
- Boundary conditions:
  - START while RUN, DRAIN or SCALE is ignored, with no restart and no corruption.
  - START held high in DONE restarts every pass.
  - Reset mid-operation aborts immediately and returns the block to IDLE with all outputs cleared.
  - Every sample is used exactly once and in address order; RD_Addr never exceeds N-1.
  - The result of (-2^(DW-1))^2 = 2^(2DW-2) fits in the positive range of 2*DW bits.

Optional Feature:
- Macro COV_ROUND_EN.
- When defined, SCALE adds 2^(LOG2N-1) to each accumulator before the arithmetic shift (round half up).
- When not defined, the shift truncates toward minus infinity.
- Latency is identical either way.

Test Plan:
- All samples x1=2, x2=3, N=128, pulse START -> COV_Done rises 130 edges after e0 with C11=4, C12=6, C22=9. RD_Addr steps 0..127 exactly once.
- x1 alternating +1/-1, x2=-x1 -> C11=1, C12=-1, C22=1. The negative accumulator sign-extends correctly.
- All samples x1=x2=-32768 -> C11=C12=C22=1073741824, with no wrap.
- LOG2N=2, x1 = 1,1,1,0, x2 = 0 -> C11=0 without COV_ROUND_EN, C11=1 with it.
- START pulses at cycles 5 and 60 after e0 -> ignored, with results as in the first scenario. A START in DONE -> COV_Done drops and a full second pass gives identical results.
- GO_cov low at address 64, released, then START -> all outputs 0 during reset. The new run yields correct results, unaffected by the partial accumulation.

Source files
------------

// File: rtl/covariance_accumulator_if.sv
// covariance_accumulator_if
// Groups the two buses of the covariance accumulator:
//   - the sample RAM read port (RD_En, RD_Addr out of the block; RD_X1, RD_X2 back in)
//   - the start/busy/done handshake and the C11/C12/C22 result bus
//     towards the whitening stage.
// Modports:
//   master : the covariance accumulator itself
//   slave  : the environment (sample RAM, centering start, whitening stage)
// Parameters:
//   DW : signed sample width per channel
//   AW : sample RAM address width
interface covariance_accumulator_if #(
  parameter int DW = 16,
  parameter int AW = 7
);
  logic                   START;
  logic                   RD_En;
  logic [AW-1:0]          RD_Addr;
  logic signed [DW-1:0]   RD_X1;
  logic signed [DW-1:0]   RD_X2;
  logic                   COV_Busy;
  logic                   COV_Done;
  logic signed [2*DW-1:0] C11;
  logic signed [2*DW-1:0] C12;
  logic signed [2*DW-1:0] C22;

  modport master (
    input  START, RD_X1, RD_X2,
    output RD_En, RD_Addr, COV_Busy, COV_Done, C11, C12, C22
  );

  modport slave (
    output START, RD_X1, RD_X2,
    input  RD_En, RD_Addr, COV_Busy, COV_Done, C11, C12, C22
  );
endinterface

// File: rtl/covariance_accumulator.sv
// covariance_accumulator
// FastICA front end, stage after centering. On START it reads the N centered
// two-channel samples from the sample RAM in address order, accumulates
// x1*x1, x1*x2 and x2*x2, divides each sum by N with an arithmetic right shift
// and presents C11, C12, C22 to the whitening stage with a busy/done handshake.
//
// Ports:
//   CLK_cov : block clock
//   GO_cov  : asynchronous active-low reset
//   bus     : covariance_accumulator_if.master
//             START (in), RD_En/RD_Addr (out), RD_X1/RD_X2 (in, data for the
//             address of the previous cycle), COV_Busy/COV_Done (out),
//             C11/C12/C22 (out, signed 2*DW)
//
// Optional feature macro: COV_ROUND_EN
//   defined     -> the divide adds 2^(LOG2N-1) before shifting (round half up)
//   not defined -> the divide truncates toward minus infinity
//   Latency is identical either way.
//
// Parameters: DW sample width, LOG2N log2 of the sample count, AW address
// width (must equal LOG2N).
module covariance_accumulator #(
  parameter int DW    = 16,
  parameter int LOG2N = 7,
  parameter int AW    = 7
) (
  input logic                      CLK_cov,
  input logic                      GO_cov,
  covariance_accumulator_if.master bus
);
  localparam int N     = 32'd1 << LOG2N;
  localparam int PW    = 2 * DW;
  localparam int ACC_W = PW + LOG2N;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_SCALE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic                    rd_en_q, rd_en_d;
  logic                    rd_v_q, rd_v_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic signed [ACC_W-1:0] acc11_q, acc11_d;
  logic signed [ACC_W-1:0] acc12_q, acc12_d;
  logic signed [ACC_W-1:0] acc22_q, acc22_d;
  logic signed [PW-1:0]    c11_q, c11_d;
  logic signed [PW-1:0]    c12_q, c12_d;
  logic signed [PW-1:0]    c22_q, c22_d;
  logic signed [PW-1:0]    p11_s, p12_s, p22_s;

  // Sign-extend a product to accumulator width; LOG2N guard bits mean N
  // worst-case products can never overflow.
  function automatic logic signed [ACC_W-1:0] widen(input logic signed [PW-1:0] p);
    return {{LOG2N{p[PW-1]}}, p};
  endfunction

  // Divide an accumulator by N and truncate to the 2*DW result width.
  // Even the rounding bias on top of the largest sum stays inside ACC_W.
  function automatic logic signed [PW-1:0] scale_acc(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;
`ifdef COV_ROUND_EN
    biased = a + ({{(ACC_W-1){1'b0}}, 1'b1} << (LOG2N - 1));
`else
    biased = a;
`endif
    shifted = biased >>> LOG2N;
    return shifted[PW-1:0];
  endfunction

  // Full-precision products of the sample pair currently on the read port.
  always_comb begin
    p11_s = PW'(bus.RD_X1) * PW'(bus.RD_X1);
    p12_s = PW'(bus.RD_X1) * PW'(bus.RD_X2);
    p22_s = PW'(bus.RD_X2) * PW'(bus.RD_X2);
  end

  // Next-state and next-output logic for the sequencer and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en_d = rd_en_q;
    busy_d  = busy_q;
    done_d  = done_q;
    acc11_d = acc11_q;
    acc12_d = acc12_q;
    acc22_d = acc22_q;
    c11_d   = c11_q;
    c12_d   = c12_q;
    c22_d   = c22_q;
    // Read data lags the address by one cycle, so validity follows RD_En by one.
    rd_v_d  = rd_en_q;

    if (rd_v_q) begin
      acc11_d = acc11_q + widen(p11_s);
      acc12_d = acc12_q + widen(p12_s);
      acc22_d = acc22_q + widen(p22_s);
    end else begin
      acc11_d = acc11_q;
      acc12_d = acc12_q;
      acc22_d = acc22_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.START) begin
          // Start or restart: previous results stay on C11..C22 until SCALE.
          state_d = S_RUN;
          cnt_d   = '0;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          acc11_d = '0;
          acc12_d = '0;
          acc22_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          rd_en_d = 1'b0;
        end else begin
          cnt_d   = cnt_q + ADDR_ONE;
        end
      end
      S_DRAIN: begin
        // Last sample's data arrives now and is accumulated on this edge.
        state_d = S_SCALE;
      end
      S_SCALE: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        c11_d   = scale_acc(acc11_q);
        c12_d   = scale_acc(acc12_q);
        c22_d   = scale_acc(acc22_q);
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        rd_en_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge CLK_cov or negedge GO_cov) begin
    if (!GO_cov) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      rd_v_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      acc11_q <= '0;
      acc12_q <= '0;
      acc22_q <= '0;
      c11_q   <= '0;
      c12_q   <= '0;
      c22_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
      rd_v_q  <= rd_v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      acc11_q <= acc11_d;
      acc12_q <= acc12_d;
      acc22_q <= acc22_d;
      c11_q   <= c11_d;
      c12_q   <= c12_d;
      c22_q   <= c22_d;
    end
  end

  assign bus.RD_En    = rd_en_q;
  assign bus.RD_Addr  = cnt_q;
  assign bus.COV_Busy = busy_q;
  assign bus.COV_Done = done_q;
  assign bus.C11      = c11_q;
  assign bus.C12      = c12_q;
  assign bus.C22      = c22_q;
endmodule

// File: tb/tb_covariance_accumulator.sv
// tb_covariance_accumulator
// Bench for covariance_accumulator: a synchronous sample RAM, a timeline
// reference model computing the expected outputs from sample sums, and a
// per-cycle compare, plus directed literal checks. A small LOG2N=2 instance
// covers the rounding-mode boundary case.
module tb_covariance_accumulator;
  localparam int DW    = 16;
  localparam int LOG2N = 7;
  localparam int N     = 128;

  logic CLK_cov = 1'b0;
  logic GO_cov  = 1'b1;

  covariance_accumulator_if #(.DW(DW), .AW(LOG2N)) bus ();
  covariance_accumulator_if #(.DW(DW), .AW(2))     bus_s ();

  covariance_accumulator #(.DW(DW), .LOG2N(LOG2N), .AW(LOG2N)) u_dut (
    .CLK_cov (CLK_cov),
    .GO_cov  (GO_cov),
    .bus     (bus)
  );

  covariance_accumulator #(.DW(DW), .LOG2N(2), .AW(2)) u_dut_small (
    .CLK_cov (CLK_cov),
    .GO_cov  (GO_cov),
    .bus     (bus_s)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  logic signed [DW-1:0] mem_x1 [0:N-1];
  logic signed [DW-1:0] mem_x2 [0:N-1];
  logic signed [DW-1:0] mem_s1 [0:3];
  int addr_log [$];

  initial forever #5 CLK_cov = ~CLK_cov;

  // Synchronous-read sample RAMs.
  always @(posedge CLK_cov) begin
    if (bus.RD_En === 1'b1) begin
      bus.RD_X1 <= mem_x1[bus.RD_Addr];
      bus.RD_X2 <= mem_x2[bus.RD_Addr];
      addr_log.push_back(int'(bus.RD_Addr));
    end
    if (bus_s.RD_En === 1'b1) begin
      bus_s.RD_X1 <= mem_s1[bus_s.RD_Addr];
      bus_s.RD_X2 <= '0;
    end
  end

  // Mean of a sum of N products, as the whitening stage expects it.
  function automatic logic signed [2*DW-1:0] mean_of(input longint s);
    longint r;
`ifdef COV_ROUND_EN
    r = (s + longint'(N / 2)) >>> LOG2N;
`else
    r = s >>> LOG2N;
`endif
    return r[2*DW-1:0];
  endfunction

  // Reference model: t counts edges since the START that began the pass.
  int     t      = -1;
  bit     m_done = 1'b0;
  logic signed [2*DW-1:0] m_c11 = '0, m_c12 = '0, m_c22 = '0;
  logic signed [2*DW-1:0] p_c11 = '0, p_c12 = '0, p_c22 = '0;

  always @(posedge CLK_cov or negedge GO_cov) begin
    if (!GO_cov) begin
      t = -1; m_done = 1'b0; m_c11 = '0; m_c12 = '0; m_c22 = '0;
    end else if ((t < 0 || m_done) && bus.START === 1'b1) begin
      longint s11, s12, s22;
      s11 = 0; s12 = 0; s22 = 0;
      for (int i = 0; i < N; i++) begin
        s11 += longint'(mem_x1[i]) * longint'(mem_x1[i]);
        s12 += longint'(mem_x1[i]) * longint'(mem_x2[i]);
        s22 += longint'(mem_x2[i]) * longint'(mem_x2[i]);
      end
      p_c11 = mean_of(s11); p_c12 = mean_of(s12); p_c22 = mean_of(s22);
      t = 0; m_done = 1'b0;
    end else if (t >= 0 && !m_done) begin
      t++;
      if (t == N + 2) begin
        m_done = 1'b1; m_c11 = p_c11; m_c12 = p_c12; m_c22 = p_c22;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge CLK_cov) begin
    if (chk_en) begin
      logic e_en, e_busy;
      logic [LOG2N-1:0] e_addr;
      e_busy = (t >= 0 && !m_done);
      e_en   = e_busy && (t <= N - 1);
      e_addr = e_en ? LOG2N'(t) : '0;
      vectors++;
      if (bus.RD_En !== e_en || bus.RD_Addr !== e_addr || bus.COV_Busy !== e_busy ||
          bus.COV_Done !== m_done || bus.C11 !== m_c11 || bus.C12 !== m_c12 || bus.C22 !== m_c22) begin
        miscompares++;
        $display("FAIL cycle_check @%0t got en=%0b addr=%0d busy=%0b done=%0b c11=%0d c12=%0d c22=%0d required en=%0b addr=%0d busy=%0b done=%0b c11=%0d c12=%0d c22=%0d",
                 $time, bus.RD_En, bus.RD_Addr, bus.COV_Busy, bus.COV_Done, bus.C11, bus.C12, bus.C22,
                 e_en, e_addr, e_busy, m_done, m_c11, m_c12, m_c22);
      end
    end
  end

  task automatic check_val(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: begin mem_x1[i] = 16'sd2; mem_x2[i] = 16'sd3; end
        1: begin mem_x1[i] = (i % 2 == 0) ? 16'sd1 : -16'sd1; mem_x2[i] = -mem_x1[i]; end
        2: begin mem_x1[i] = -16'sd32768; mem_x2[i] = -16'sd32768; end
        3: begin mem_x1[i] = 16'($urandom); mem_x2[i] = 16'($urandom); end
        default: begin
          case ($urandom_range(0, 3))
            0: mem_x1[i] = -16'sd32768;
            1: mem_x1[i] = 16'sd32767;
            2: mem_x1[i] = -16'sd1;
            default: mem_x1[i] = 16'($urandom);
          endcase
          mem_x2[i] = ($urandom_range(0, 1) == 0) ? -16'sd32768 : 16'($urandom);
        end
      endcase
    end
  endtask

  // One pass from a negedge; extra START pulses are sampled at edges e<extra>.
  task automatic do_pass(input int extra_a, input int extra_b, output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    addr_log.delete();
    bus.START = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK_cov);
      if (bus.COV_Done === 1'b1) begin
        bus.START = 1'b0; lat = i; got = 1'b1;
        break;
      end
      bus.START = ((i + 1) == extra_a || (i + 1) == extra_b) ? 1'b1 : 1'b0;
    end
    bus.START = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL pass_timeout: got no COV_Done within 400 cycles, required done at 130");
    end
  endtask

  task automatic check_addr_log();
    int bad;
    bad = -1;
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != i && bad < 0) bad = i;
    vectors++;
    if (addr_log.size() != N || bad >= 0) begin
      miscompares++;
      $display("FAIL addr_sequence: got %0d reads (first out of order at %0d), required %0d reads 0..127", addr_log.size(), bad, N);
    end
  endtask

  task automatic check_c(input string tag, input longint e11, input longint e12, input longint e22);
    check_val({tag, "_c11"}, bus.C11, e11);
    check_val({tag, "_c12"}, bus.C12, e12);
    check_val({tag, "_c22"}, bus.C22, e22);
  endtask

  initial begin
    int lat, cnt;
    bit got;
    bus.START   = 1'b0;
    bus_s.START = 1'b0;
    #1 GO_cov = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge CLK_cov);
    check_val("reset_busy", bus.COV_Busy, 0);
    check_val("reset_done", bus.COV_Done, 0);
    check_c("reset", 0, 0, 0);
    #2 GO_cov = 1'b1;
    @(negedge CLK_cov);

    // Constant 2/3 samples with ignored START pulses mid-run.
    fill(0);
    do_pass(5, 60, lat);
    check_val("s1_latency", lat, 130);
    check_c("s1", 4, 6, 9);
    check_addr_log();
    // Restart from DONE gives identical results.
    do_pass(0, 0, lat);
    check_c("s1_restart", 4, 6, 9);
    check_addr_log();

    fill(1);
    do_pass(0, 0, lat);
    check_c("alt", 1, -1, 1);

    fill(2);
    do_pass(0, 0, lat);
    check_c("min", 1073741824, 1073741824, 1073741824);

    for (int k = 0; k < 4; k++) begin
      fill(3 + (k % 2));
      do_pass($urandom_range(1, N + 2), $urandom_range(1, N + 2), lat);
      check_val("rand_latency", lat, 130);
    end

    // START held high through DONE restarts every pass.
    fill(4);
    cnt = 0;
    bus.START = 1'b1;
    for (int i = 0; i < 800 && cnt < 2; i++) begin
      @(negedge CLK_cov);
      if (bus.COV_Done === 1'b1) cnt++;
    end
    bus.START = 1'b0;
    check_val("held_start_passes", cnt, 2);

    // Reset in the middle of a pass.
    fill(3);
    bus.START = 1'b1;
    @(negedge CLK_cov);
    bus.START = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.RD_Addr === 7'd64) begin got = 1'b1; break; end
      @(negedge CLK_cov);
    end
    check_val("reach_addr64", got, 1);
    #2 GO_cov = 1'b0;
    repeat (3) @(negedge CLK_cov);
    check_val("midreset_en", bus.RD_En, 0);
    check_val("midreset_addr", bus.RD_Addr, 0);
    check_val("midreset_busy", bus.COV_Busy, 0);
    check_c("midreset", 0, 0, 0);
    #2 GO_cov = 1'b1;
    @(negedge CLK_cov);
    fill(0);
    do_pass(0, 0, lat);
    check_c("after_reset", 4, 6, 9);
    check_addr_log();

    // LOG2N=2 instance: x1 = 1,1,1,0 and x2 = 0.
    mem_s1[0] = 16'sd1; mem_s1[1] = 16'sd1; mem_s1[2] = 16'sd1; mem_s1[3] = 16'sd0;
    bus_s.START = 1'b1;
    @(negedge CLK_cov);
    bus_s.START = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus_s.COV_Done === 1'b1) begin got = 1'b1; break; end
      @(negedge CLK_cov);
    end
    check_val("small_done", got, 1);
`ifdef COV_ROUND_EN
    check_val("small_c11", bus_s.C11, 1);
`else
    check_val("small_c11", bus_s.C11, 0);
`endif
    check_val("small_c12", bus_s.C12, 0);
    check_val("small_c22", bus_s.C22, 0);

    repeat (2) @(negedge CLK_cov);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
